// File: rtl/dm_ext.sv
// dm_ext: byte-addressable word memory with sized, sign/zero-extended loads; DM_EXT_CLEAR_EN adds a zeroing sweep after reset
module dm_ext #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        uext,
  input  logic [31:0] din,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] dout,
  output logic        misalign
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [31:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx, widx, clr_idx;
  logic [1:0] lane;
  logic clr, acc, mis, resp;
  logic [3:0] be, wbe;
  logic [31:0] sdat, wdat, rw, sh, ld;
  logic rvalid_q, rvalid_d, misalign_q, misalign_d;
  logic [31:0] dout_q, dout_d;
  logic unused_addr;
  assign idx = addr[ADDR_W+1:2];
  assign lane = addr[1:0];
  assign unused_addr = ^addr[31:ADDR_W+2];
`ifdef DM_EXT_CLEAR_EN
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  // state and sweep counter; reset restarts the sweep at word 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  // sweep one word per cycle, leave CLEAR on the edge that zeroes the last word
  always_comb begin
    state_d = (state_q == CLEAR && &cnt_q) ? IDLE : state_q;
    cnt_d   = (state_q == CLEAR) ? cnt_q + 1'b1 : cnt_q;
  end
  assign ready   = state_q == IDLE;
  assign clr     = state_q == CLEAR && !rst;
  assign clr_idx = cnt_q;
`else
  logic ready_q;
  // accept requests from the first edge after reset releases
  always_ff @(posedge clk or posedge rst)
    if (rst) ready_q <= 1'b0;
    else ready_q <= 1'b1;
  assign ready   = ready_q;
  assign clr     = 1'b0;
  assign clr_idx = '0;
`endif
  // request decode, store lane steering, load extraction and response next-state
  always_comb begin
    acc        = req & ready;
    mis        = size == 2'b11 | (size == 2'b01 & addr[0]) | (size == 2'b10 & |lane);
    be         = size == 2'b00 ? 4'b0001 << lane : size == 2'b01 ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
    sdat       = size == 2'b00 ? {4{din[7:0]}} : size == 2'b01 ? {2{din[15:0]}} : din;
    wbe        = clr ? 4'hF : (acc & we & !mis) ? be : 4'h0;
    widx       = clr ? clr_idx : idx;
    wdat       = clr ? '0 : sdat;
    rw         = mem[idx];
    sh         = rw >> {lane, 3'b000};
    ld         = size == 2'b00 ? {{24{sh[7] & !uext}}, sh[7:0]} :
                 size == 2'b01 ? {{16{sh[15] & !uext}}, sh[15:0]} : rw;
    resp       = acc & (!we | mis);
    rvalid_d   = resp;
    misalign_d = acc & mis;
    dout_d     = resp ? (mis ? '0 : ld) : dout_q;
  end
  // memory array has no reset; only the sweep or accepted stores change it
  always_ff @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (wbe[b]) mem[widx][8*b +: 8] <= wdat[8*b +: 8];
  // registered load/error response
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      dout_q     <= '0;
    end else begin
      rvalid_q   <= rvalid_d;
      misalign_q <= misalign_d;
      dout_q     <= dout_d;
    end
  assign rvalid   = rvalid_q;
  assign misalign = misalign_q;
  assign dout     = dout_q;
endmodule

// File: tb/tb_dm_ext.sv
// tb_dm_ext: random and directed checks of dm_ext against a byte-array reference model
module tb_dm_ext;
  localparam int AW = 4;
  localparam int DEPTH = 16;
`ifdef DM_EXT_CLEAR_EN
  localparam int RDY_CYC = DEPTH;
`else
  localparam int RDY_CYC = 1;
`endif
  logic clk = 0, rst = 1, req = 0, we = 0, uext = 0;
  logic [31:0] addr = 0, din = 0;
  logic [1:0] size = 0;
  logic ready, rvalid, misalign;
  logic [31:0] dout;
  int chk = 0, err = 0;
  logic [7:0] mem_m [4*DEPTH];
  logic [31:0] exp_dout = 0;

  dm_ext #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .size(size),
    .uext(uext), .din(din), .ready(ready), .rvalid(rvalid), .dout(dout), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return sz == 0 ? 1 : sz == 1 ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input int b, input logic [1:0] sz, input logic ue);
    int n = nbytes(sz);
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(mem_m[b+i]) << (8*i);
    if (n < 4 && !ue && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
    return 32'(v);
  endfunction

  task automatic m_store(input int b, input logic [1:0] sz, input logic [31:0] d);
    for (int i = 0; i < nbytes(sz); i++) mem_m[b+i] = 8'(d >> (8*i));
  endtask

  task automatic m_clear();
    for (int i = 0; i < 4*DEPTH; i++) mem_m[i] = 8'h00;
  endtask

  task automatic op(input string tag, input logic w, input logic [31:0] a, input logic [1:0] sz,
                    input logic ue, input logic [31:0] d);
    int b = int'(a[5:0]);
    logic m = sz == 3 || (sz == 1 && b % 2 != 0) || (sz == 2 && b % 4 != 0);
    if (!w || m) exp_dout = m ? 32'h0 : m_load(b, sz, ue);
    if (w && !m) m_store(b, sz, d);
    req = 1; we = w; addr = a; size = sz; uext = ue; din = d;
    check({tag, ".ready"}, ready, 1);
    @(posedge clk); #1;
    req = 0;
    check({tag, ".rvalid"}, rvalid, (!w || m) ? 1 : 0);
    check({tag, ".misalign"}, misalign, m);
    check({tag, ".dout"}, dout, exp_dout);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
      check({tag, ".quiet"}, rvalid, 0);
    end
    req = 0;
    check({tag, ".cycles"}, n, RDY_CYC);
  endtask

  initial begin
    m_clear();
    rst = 1; req = 1; we = 1; addr = 0; size = 2; din = 32'hFFFFFFFF;
    @(posedge clk); #1;
    check("rst.ready", ready, 0);
    check("rst.rvalid", rvalid, 0);
    check("rst.misalign", misalign, 0);
    check("rst.dout", dout, 0);
    rst = 0;
    wait_ready("boot");
`ifndef DM_EXT_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) op("init", 1, 32'(4*i), 2, 0, 0);
`endif
    op("lw3c", 0, 32'h3C, 2, 0, 0);
    op("lw0", 0, 32'h0, 2, 0, 0);
    op("sw8", 1, 32'h8, 2, 0, 32'h11223344);
    op("sb9", 1, 32'h9, 0, 0, 32'h000000AB);
    op("lw8", 0, 32'h8, 2, 1, 0);
    op("lb9", 0, 32'h9, 0, 0, 0);
    op("lbu9", 0, 32'h9, 0, 1, 0);
    op("sh12", 1, 32'h12, 1, 0, 32'h00008001);
    op("lh12", 0, 32'h12, 1, 0, 0);
    op("lhu12", 0, 32'h12, 1, 1, 0);
    op("lw10", 0, 32'h10, 2, 0, 0);
    op("sw4", 1, 32'h4, 2, 0, 32'hCAFEF00D);
    op("lw5", 0, 32'h5, 2, 0, 0);
    op("sh7", 1, 32'h7, 1, 0, 32'h00001234);
    op("lw4", 0, 32'h4, 2, 0, 0);
    op("ill", 0, 32'h4, 3, 0, 0);
    op("sw0", 1, 32'h0, 2, 0, 32'hDEADBEEF);
    op("lwwrap", 0, 32'(4*DEPTH), 2, 0, 0);
    op("lbhi", 0, 32'hFFFFFFC3, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      logic w = 1'($urandom_range(0, 1));
      logic [1:0] sz = 2'($urandom_range(0, 3));
      logic [31:0] a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 1) a[0] = 1'b0;
        if (sz == 2) a[1:0] = 2'b00;
      end
      op("rnd", w, a, sz, 1'($urandom_range(0, 1)), $urandom);
    end
    req = 1; we = 0; addr = 32'h8; size = 2;
    #2 rst = 1;
    @(posedge clk); #1;
    req = 0;
    exp_dout = 0;
    check("flight.rvalid", rvalid, 0);
    check("flight.dout", dout, 0);
`ifdef DM_EXT_CLEAR_EN
    m_clear();
`endif
    rst = 0;
    wait_ready("rel1");
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    repeat (5) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    wait_ready("midclr");
    for (int i = 0; i < DEPTH; i++) op("post", 0, 32'(4*i), 2, 0, 0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
